// File: rtl/regbank_wr_ctrl.sv
// regbank_wr_ctrl: write-request controller in front of the register bank's
// 5-bit-select write decoder. Two writeback sources (A: ALU, high priority;
// B: load, starvation-protected) are arbitrated into a small FIFO. Entries are
// issued one per cycle as wr_en/wr_sel/wr_data. A pending mask of the
// destination registers still in the FIFO is published for hazard checks.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   a_valid/a_ready/a_sel/a_data  port A request handshake and payload
//   b_valid/b_ready/b_sel/b_data  port B request handshake and payload
//   wr_stall                    bank cannot accept a write this cycle
//   wr_en, wr_sel, wr_data      issue strobe, destination index, data
//   pending                     bit i set while a buffered entry targets reg i
//
// Optional feature: define REGBANK_R0_DROP_EN to complete but discard writes
// to register 0 instead of buffering them.

module regbank_wr_ctrl #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_sel,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_sel,
    input  logic [31:0] b_data,
    input  logic        wr_stall,
    output logic        wr_en,
    output logic [4:0]  wr_sel,
    output logic [31:0] wr_data,
    output logic [31:0] pending
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SC_W  = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [SC_W-1:0]  SC_MAX   = SC_W'(STARVE_MAX);

    logic [4:0]       sel_mem  [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [SC_W-1:0]  starve_cnt;

    logic        empty;
    logic        full;
    logic        force_b;
    logic        a_xfer;
    logic        b_xfer;
    logic        push;
    logic        pop;
    logic [4:0]  push_sel;
    logic [31:0] push_data;

    // Arbitration, handshake and issue decode
    always_comb begin
        empty   = (count == '0);
        full    = (count == FULL_CNT);
        force_b = b_valid && (starve_cnt == SC_MAX);
        a_ready = !full && !force_b;
        b_ready = !full && (!a_valid || force_b);
        a_xfer  = a_valid && a_ready;
        b_xfer  = b_valid && b_ready;

        // a_xfer and b_xfer are mutually exclusive by construction
        push_sel  = b_xfer ? b_sel  : a_sel;
        push_data = b_xfer ? b_data : a_data;
`ifdef REGBANK_R0_DROP_EN
        push = (a_xfer || b_xfer) && (push_sel != 5'd0);
`else
        push = a_xfer || b_xfer;
`endif
        pop = !empty && !wr_stall;

        wr_en   = pop;
        wr_sel  = empty ? 5'd0  : sel_mem[rd_ptr];
        wr_data = empty ? 32'd0 : data_mem[rd_ptr];
    end

    // Pending mask: walk the live entries from head for count slots
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count) begin
                pending[sel_mem[rd_ptr + PTR_W'(i)]] = 1'b1;
            end
        end
    end

    // Control state: pointers, occupancy, starvation counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            if (!b_valid || b_xfer) begin
                starve_cnt <= '0;
            end else if (a_xfer && (starve_cnt != SC_MAX)) begin
                starve_cnt <= starve_cnt + SC_W'(1);
            end
        end
    end

    // Storage needs no reset: only slots counted by count are ever observed
    always_ff @(posedge clk) begin
        if (push) begin
            sel_mem[wr_ptr]  <= push_sel;
            data_mem[wr_ptr] <= push_data;
        end
    end

endmodule
